// File: rtl/periph_csb_bridge.sv
// Bridge from an HWPE peripheral target port to an NVDLA CSB master port.
// Each granted request becomes one CSB transaction; only one is outstanding at a time.
module periph_csb_bridge #(
  parameter int unsigned ID_WIDTH = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                periph_req_i,
  input  logic [31:0]         periph_add_i,
  input  logic                periph_wen_i,
  input  logic [3:0]          periph_be_i,
  input  logic [31:0]         periph_data_i,
  input  logic [ID_WIDTH-1:0] periph_id_i,
  output logic                periph_gnt_o,
  output logic [31:0]         periph_r_data_o,
  output logic                periph_r_valid_o,
  output logic [ID_WIDTH-1:0] periph_r_id_o,
  input  logic                csb_ready_i,
  input  logic                csb_r_valid_i,
  input  logic [31:0]         csb_r_data_i,
  input  logic                csb_wr_complete_i,
  output logic                csb_valid_o,
  output logic [15:0]         csb_addr_o,
  output logic [31:0]         csb_wdat_o,
  output logic                csb_write_o,
  output logic                csb_nposted_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [ID_WIDTH-1:0] pend_id_q, pend_id_d;
  logic                pend_wr_q, pend_wr_d;
  logic                r_valid_q, r_valid_d;
  logic [31:0]         r_data_q, r_data_d;
  logic [ID_WIDTH-1:0] r_id_q, r_id_d;

  logic busy;
  logic gnt;
  logic resp_evt;

  // CSB is full-word only, so byte enables and sub-word / high address bits are dropped.
  logic unused_inputs;
  assign unused_inputs = ^{periph_be_i, periph_add_i[31:18], periph_add_i[1:0]};

  assign busy = (state_q == WAIT);
  assign gnt  = periph_req_i & csb_ready_i & ~busy;

  assign csb_valid_o   = periph_req_i & ~busy;
  assign csb_addr_o    = periph_add_i[17:2];
  assign csb_wdat_o    = periph_data_i;
  assign csb_write_o   = ~periph_wen_i;
  assign csb_nposted_o = 1'b1;
  assign periph_gnt_o  = gnt;

  // Only the completion signal matching the pending direction counts.
  assign resp_evt = pend_wr_q ? csb_wr_complete_i : csb_r_valid_i;

  always_comb begin
    state_d   = state_q;
    pend_id_d = pend_id_q;
    pend_wr_d = pend_wr_q;
    r_valid_d = 1'b0;
    r_data_d  = r_data_q;
    r_id_d    = r_id_q;
    if (state_q == IDLE) begin
      if (gnt) begin
        state_d   = WAIT;
        pend_id_d = periph_id_i;
        pend_wr_d = ~periph_wen_i;
      end
    end else begin
      if (resp_evt) begin
        state_d   = IDLE;
        r_valid_d = 1'b1;
        r_data_d  = pend_wr_q ? 32'h0 : csb_r_data_i;
        r_id_d    = pend_id_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pend_id_q <= '0;
      pend_wr_q <= 1'b0;
      r_valid_q <= 1'b0;
      r_data_q  <= 32'h0;
      r_id_q    <= '0;
    end else begin
      state_q   <= state_d;
      pend_id_q <= pend_id_d;
      pend_wr_q <= pend_wr_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      r_id_q    <= r_id_d;
    end
  end

  assign periph_r_valid_o = r_valid_q;
  assign periph_r_data_o  = r_data_q;
  assign periph_r_id_o    = r_id_q;

endmodule

// File: tb/tb_periph_csb_bridge.sv
// Scoreboard bench for periph_csb_bridge: stimulus pushes expected responses,
// a negedge monitor compares outputs against them and against per-cycle request expectations.
module tb_periph_csb_bridge;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          periph_req_i;
  logic [31:0]   periph_add_i;
  logic          periph_wen_i;
  logic [3:0]    periph_be_i;
  logic [31:0]   periph_data_i;
  logic [IW-1:0] periph_id_i;
  logic          periph_gnt_o;
  logic [31:0]   periph_r_data_o;
  logic          periph_r_valid_o;
  logic [IW-1:0] periph_r_id_o;
  logic          csb_ready_i;
  logic          csb_r_valid_i;
  logic [31:0]   csb_r_data_i;
  logic          csb_wr_complete_i;
  logic          csb_valid_o;
  logic [15:0]   csb_addr_o;
  logic [31:0]   csb_wdat_o;
  logic          csb_write_o;
  logic          csb_nposted_o;

  periph_csb_bridge #(.ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst),
    .periph_req_i(periph_req_i), .periph_add_i(periph_add_i), .periph_wen_i(periph_wen_i),
    .periph_be_i(periph_be_i), .periph_data_i(periph_data_i), .periph_id_i(periph_id_i),
    .periph_gnt_o(periph_gnt_o), .periph_r_data_o(periph_r_data_o),
    .periph_r_valid_o(periph_r_valid_o), .periph_r_id_o(periph_r_id_o),
    .csb_ready_i(csb_ready_i), .csb_r_valid_i(csb_r_valid_i), .csb_r_data_i(csb_r_data_i),
    .csb_wr_complete_i(csb_wr_complete_i), .csb_valid_o(csb_valid_o), .csb_addr_o(csb_addr_o),
    .csb_wdat_o(csb_wdat_o), .csb_write_o(csb_write_o), .csb_nposted_o(csb_nposted_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0]   data;
    logic [IW-1:0] id;
    int            cyc;
  } resp_t;

  resp_t exp_q[$];
  bit    exp_gnt, exp_cvalid;
  bit    chk_en = 1'b0;
  bit    done = 1'b0;
  int    total = 0;
  int    bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: request-side outputs every cycle, response side against the scoreboard.
  logic [31:0]   last_data = 32'h0;
  logic [IW-1:0] last_id = '0;
  bit            rst_pend = 1'b0;
  bit            final_done = 1'b0;
  resp_t         e;

  always @(negedge clk) begin
    if (rst_pend) begin
      last_data = 32'h0;
      last_id   = '0;
    end
    rst_pend = rst;
    if (chk_en) begin
      chk("gnt", {31'h0, periph_gnt_o}, {31'h0, exp_gnt});
      chk("csb_valid", {31'h0, csb_valid_o}, {31'h0, exp_cvalid});
      chk("csb_addr", {16'h0, csb_addr_o}, (periph_add_i >> 2) & 32'h0000_FFFF);
      chk("csb_wdat", csb_wdat_o, periph_data_i);
      chk("csb_write", {31'h0, csb_write_o}, {31'h0, !periph_wen_i});
      chk("csb_nposted", {31'h0, csb_nposted_o}, 32'h1);
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        chk("r_valid", {31'h0, periph_r_valid_o}, 32'h1);
        chk("r_data", periph_r_data_o, e.data);
        chk("r_id", {{(32-IW){1'b0}}, periph_r_id_o}, {{(32-IW){1'b0}}, e.id});
        last_data = e.data;
        last_id   = e.id;
      end else begin
        chk("r_valid_idle", {31'h0, periph_r_valid_o}, 32'h0);
        chk("r_data_hold", periph_r_data_o, last_data);
        chk("r_id_hold", {{(32-IW){1'b0}}, periph_r_id_o}, {{(32-IW){1'b0}}, last_id});
      end
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        chk("missed_resp", 32'h0, 32'h1);
      end
    end
    if (done && !final_done) begin
      final_done = 1'b1;
      chk("queue_empty", exp_q.size(), 32'h0);
    end
  end

  task automatic idle_cycle(input bit stray);
    periph_req_i      = 1'b0;
    periph_add_i      = $urandom;
    periph_wen_i      = 1'($urandom_range(0, 1));
    periph_be_i       = 4'($urandom);
    periph_data_i     = $urandom;
    periph_id_i       = IW'($urandom);
    csb_ready_i       = 1'($urandom_range(0, 1));
    csb_r_valid_i     = stray ? 1'($urandom_range(0, 1)) : 1'b0;
    csb_r_data_i      = $urandom;
    csb_wr_complete_i = stray ? 1'($urandom_range(0, 1)) : 1'b0;
    exp_gnt           = 1'b0;
    exp_cvalid        = 1'b0;
    tick();
  endtask

  // One full transaction: rdly cycles of backpressure, wdly cycles of waiting,
  // then the CSB completion. busy_req keeps req high while outstanding.
  task automatic do_txn(input bit wr, input logic [31:0] add, input logic [31:0] data,
                        input logic [IW-1:0] id, input int rdly, input int wdly,
                        input logic [31:0] rdata, input bit busy_req);
    resp_t r;
    for (int i = 0; i <= rdly; i++) begin
      periph_req_i      = 1'b1;
      periph_wen_i      = !wr;
      periph_add_i      = add;
      periph_data_i     = data;
      periph_id_i       = id;
      periph_be_i       = 4'($urandom);
      csb_ready_i       = (i == rdly);
      csb_r_valid_i     = 1'($urandom_range(0, 1));
      csb_wr_complete_i = 1'($urandom_range(0, 1));
      csb_r_data_i      = $urandom;
      exp_cvalid        = 1'b1;
      exp_gnt           = (i == rdly);
      tick();
    end
    for (int i = 0; i <= wdly; i++) begin
      periph_req_i  = busy_req ? 1'b1 : 1'($urandom_range(0, 1));
      periph_wen_i  = 1'($urandom_range(0, 1));
      periph_add_i  = $urandom;
      periph_data_i = $urandom;
      periph_id_i   = IW'($urandom);
      csb_ready_i   = busy_req ? 1'b1 : 1'($urandom_range(0, 1));
      csb_r_data_i  = $urandom;
      exp_cvalid    = 1'b0;
      exp_gnt       = 1'b0;
      if (i < wdly) begin
        csb_r_valid_i     = wr ? 1'($urandom_range(0, 1)) : 1'b0;
        csb_wr_complete_i = wr ? 1'b0 : 1'($urandom_range(0, 1));
      end else begin
        csb_r_valid_i     = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        csb_wr_complete_i = wr ? 1'b1 : 1'($urandom_range(0, 1));
        csb_r_data_i      = rdata;
        r.data = wr ? 32'h0 : rdata;
        r.id   = id;
        r.cyc  = cyc + 1;
        exp_q.push_back(r);
      end
      tick();
    end
    periph_req_i      = 1'b0;
    csb_r_valid_i     = 1'b0;
    csb_wr_complete_i = 1'b0;
    exp_gnt           = 1'b0;
    exp_cvalid        = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_cycle(1'b0);
    idle_cycle(1'b1);
    idle_cycle(1'b0);
    rst = 1'b0;
    chk_en = 1'b1;
    idle_cycle(1'b0);

    do_txn(1'b0, 32'h0000_1004, 32'h0, 2'd1, 0, 1, 32'hDEADBEEF, 1'b0);
    idle_cycle(1'b0);
    do_txn(1'b1, 32'h0000_0008, 32'h12345678, 2'd2, 0, 0, 32'h0, 1'b0);
    idle_cycle(1'b0);
    do_txn(1'b0, 32'hFFFF_FFFC, 32'h0, 2'd3, 3, 2, 32'hA5A5_5A5A, 1'b0);
    do_txn(1'b1, 32'h0003_FFFC, 32'hCAFEF00D, 2'd0, 0, 3, 32'h0, 1'b1);
    do_txn(1'b0, 32'h0000_0010, 32'h0, 2'd2, 0, 2, 32'h0BAD_F00D, 1'b1);
    for (int i = 0; i < 6; i++) idle_cycle(1'b1);

    // Reset while a read is outstanding; a completion in the reset cycle must be dropped.
    periph_req_i  = 1'b1;
    periph_wen_i  = 1'b1;
    periph_add_i  = 32'h0000_0100;
    periph_id_i   = 2'd3;
    csb_ready_i   = 1'b1;
    exp_gnt       = 1'b1;
    exp_cvalid    = 1'b1;
    tick();
    periph_req_i  = 1'b0;
    exp_gnt       = 1'b0;
    exp_cvalid    = 1'b0;
    tick();
    rst           = 1'b1;
    csb_r_valid_i = 1'b1;
    csb_r_data_i  = 32'h1111_2222;
    tick();
    rst           = 1'b0;
    csb_r_valid_i = 1'b0;
    do_txn(1'b0, 32'h0000_0200, 32'h0, 2'd1, 0, 0, 32'h3333_4444, 1'b0);

    for (int n = 0; n < 60; n++) begin
      do_txn(1'($urandom_range(0, 1)), $urandom, $urandom, IW'($urandom),
             int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), $urandom,
             1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_cycle(1'b1);
    end

    idle_cycle(1'b0);
    idle_cycle(1'b0);
    done = 1'b1;
    idle_cycle(1'b0);
    idle_cycle(1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
